ifft_butterfly_dif: RTL and testbench

IFFT_BUTTERFLY_DIF -- requirements
Module: ifft_butterfly_dif

---
 rtl/ifft_butterfly_dif.sv | 158 +++++++++++++++
 tb/tb_ifft_butterfly_dif.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_butterfly_dif.sv
// Radix-2 decimation-in-frequency inverse butterfly: out1 = s(a+b), out2 = s(a-b)conj(W_k).
// Four register stages share one advance enable derived from the output handshake.
module ifft_butterfly_dif #(
    parameter int DATA_W = 30,
    parameter int TW_W   = 22,
    parameter int FRAC   = 20
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a_real,
    input  logic signed [DATA_W-1:0] in_a_imag,
    input  logic signed [DATA_W-1:0] in_b_real,
    input  logic signed [DATA_W-1:0] in_b_imag,
    input  logic [6:0]               twiddle_idx,
    input  logic                     scale_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out1_real,
    output logic signed [DATA_W-1:0] out1_imag,
    output logic signed [DATA_W-1:0] out2_real,
    output logic signed [DATA_W-1:0] out2_imag
);
    localparam int SW = DATA_W + 1;
    localparam int SX = SW + 1;
    localparam int PW = SW + TW_W;
    localparam int AW = PW + 1;
    localparam logic signed [AW-1:0] RND  = AW'(1) <<< (FRAC - 1);
    localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (DATA_W - 1)) - AW'(1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    // Elaboration-time Taylor series; conj(W_k) = cos(pi*k/128) + j*sin(pi*k/128) in Q1.FRAC.
    function automatic int tw_val(input int k, input bit want_sin);
        real x, term, acc, r;
        x    = 3.14159265358979323846 * real'(k) / 128.0;
        term = want_sin ? x : 1.0;
        acc  = term;
        for (int unsigned n = 1; n < 30; n++) begin
            if (want_sin) term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            else          term = -term * x * x / (real'(2 * n - 1) * real'(2 * n));
            acc += term;
        end
        r = acc;
        for (int unsigned i = 0; i < FRAC; i++) r = r * 2.0;
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] x,
                                                   input logic                 do_half);
        logic signed [SX-1:0] t;
        t = (SX'(x) + SX'(1)) >>> 1;
        return do_half ? t[SW-1:0] : x;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [AW-1:0] x);
        if (x > MAXV)      return MAXV[DATA_W-1:0];
        else if (x < MINV) return MINV[DATA_W-1:0];
        else               return x[DATA_W-1:0];
    endfunction

    logic signed [TW_W-1:0] cos_rom [128];
    logic signed [TW_W-1:0] sin_rom [128];

    for (genvar k = 0; k < 128; k++) begin : g_tw
        localparam int COS_K = tw_val(k, 1'b0);
        localparam int SIN_K = tw_val(k, 1'b1);
        assign cos_rom[k] = TW_W'(COS_K);
        assign sin_rom[k] = TW_W'(SIN_K);
    end

    logic                     en;
    logic                     v1_q, v2_q, v3_q, out_valid_q;
    logic signed [DATA_W-1:0] ar1_q, ai1_q, br1_q, bi1_q;
    logic                     sc1_q;
    logic signed [TW_W-1:0]   wr1_q, wi1_q, wr2_q, wi2_q;
    logic signed [SW-1:0]     s_re_d, s_im_d, d_re_d, d_im_d;
    logic signed [SW-1:0]     s_re2_q, s_im2_q, d_re2_q, d_im2_q, s_re3_q, s_im3_q;
    logic signed [PW-1:0]     p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0]     p_rr3_q, p_ii3_q, p_ri3_q, p_ir3_q;
    logic signed [AW-1:0]     re_acc_d, im_acc_d, re_rnd_d, im_rnd_d;
    logic signed [DATA_W-1:0] o1_re_d, o1_im_d, o2_re_d, o2_im_d;
    logic signed [DATA_W-1:0] o1_re_q, o1_im_q, o2_re_q, o2_im_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        s_re_d   = halve(SW'(ar1_q) + SW'(br1_q), sc1_q);
        s_im_d   = halve(SW'(ai1_q) + SW'(bi1_q), sc1_q);
        d_re_d   = halve(SW'(ar1_q) - SW'(br1_q), sc1_q);
        d_im_d   = halve(SW'(ai1_q) - SW'(bi1_q), sc1_q);
        p_rr_d   = PW'(d_re2_q) * PW'(wr2_q);
        p_ii_d   = PW'(d_im2_q) * PW'(wi2_q);
        p_ri_d   = PW'(d_re2_q) * PW'(wi2_q);
        p_ir_d   = PW'(d_im2_q) * PW'(wr2_q);
        re_acc_d = AW'(p_rr3_q) - AW'(p_ii3_q);
        im_acc_d = AW'(p_ri3_q) + AW'(p_ir3_q);
        re_rnd_d = (re_acc_d + RND) >>> FRAC;
        im_rnd_d = (im_acc_d + RND) >>> FRAC;
        o1_re_d  = sat(AW'(s_re3_q));
        o1_im_d  = sat(AW'(s_im3_q));
        o2_re_d  = sat(re_rnd_d);
        o2_im_d  = sat(im_rnd_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            o1_re_q     <= '0;
            o1_im_q     <= '0;
            o2_re_q     <= '0;
            o2_im_q     <= '0;
        end else if (en) begin
            v1_q    <= in_valid;
            ar1_q   <= in_a_real;
            ai1_q   <= in_a_imag;
            br1_q   <= in_b_real;
            bi1_q   <= in_b_imag;
            sc1_q   <= scale_en;
            wr1_q   <= cos_rom[twiddle_idx];
            wi1_q   <= sin_rom[twiddle_idx];

            v2_q    <= v1_q;
            s_re2_q <= s_re_d;
            s_im2_q <= s_im_d;
            d_re2_q <= d_re_d;
            d_im2_q <= d_im_d;
            wr2_q   <= wr1_q;
            wi2_q   <= wi1_q;

            v3_q    <= v2_q;
            s_re3_q <= s_re2_q;
            s_im3_q <= s_im2_q;
            p_rr3_q <= p_rr_d;
            p_ii3_q <= p_ii_d;
            p_ri3_q <= p_ri_d;
            p_ir3_q <= p_ir_d;

            out_valid_q <= v3_q;
            if (v3_q) begin
                o1_re_q <= o1_re_d;
                o1_im_q <= o1_im_d;
                o2_re_q <= o2_re_d;
                o2_im_q <= o2_im_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out1_real = o1_re_q;
    assign out1_imag = o1_im_q;
    assign out2_real = o2_re_q;
    assign out2_imag = o2_im_q;
endmodule

// File: tb/tb_ifft_butterfly_dif.sv
// Bench for ifft_butterfly_dif: directed vectors, literal expectations and a
// floating-point-twiddle reference model checked against every delivered result.
module tb_ifft_butterfly_dif;
    localparam int DW = 30;
    localparam int TW = 22;
    localparam int FR = 20;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic [6:0]           tw_idx = '0;
    logic                 scale = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] o1r, o1i, o2r, o2i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        longint o1r, o1i, o2r, o2i;
    } res_t;
    res_t exp_q[$];

    always #5 clock = ~clock;

    ifft_butterfly_dif #(.DATA_W(DW), .TW_W(TW), .FRAC(FR)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_real(a_re), .in_a_imag(a_im), .in_b_real(b_re), .in_b_imag(b_im),
        .twiddle_idx(tw_idx), .scale_en(scale), .out_valid(out_valid), .out_ready(out_ready),
        .out1_real(o1r), .out1_imag(o1i), .out2_real(o2r), .out2_imag(o2i)
    );

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: ideal trig rounded to Q1.20, exact integer arithmetic, then clamp.
    function automatic longint tw(input int k, input bit im);
        real ang, v;
        ang = 2.0 * 3.141592653589793 * real'(k) / 256.0;
        v   = im ? $sin(ang) : $cos(ang);
        return longint'($floor(v * 1048576.0 + 0.5));
    endfunction

    function automatic longint sat(input longint x);
        longint lim;
        lim = longint'(1) << (DW - 1);
        if (x > lim - 1) return lim - 1;
        if (x < -lim)    return -lim;
        return x;
    endfunction

    function automatic longint scl(input longint x, input bit s);
        return s ? ((x + 1) >>> 1) : x;
    endfunction

    function automatic longint rnd(input longint x);
        return (x + (longint'(1) << (FR - 1))) >>> FR;
    endfunction

    function automatic res_t model(input longint ar, ai, br, bi, input int k, input bit s);
        res_t   r;
        longint dr, di, wr, wi;
        dr    = scl(ar - br, s);
        di    = scl(ai - bi, s);
        wr    = tw(k, 1'b0);
        wi    = tw(k, 1'b1);
        r.o1r = sat(scl(ar + br, s));
        r.o1i = sat(scl(ai + bi, s));
        r.o2r = sat(rnd(dr * wr - di * wi));
        r.o2i = sat(rnd(dr * wi + di * wr));
        return r;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            check("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", longint'(out_valid), 0);
                end else begin
                    check("out1_re", o1r, exp_q[0].o1r);
                    check("out1_im", o1i, exp_q[0].o1i);
                    check("out2_re", o2r, exp_q[0].o2r);
                    check("out2_im", o2i, exp_q[0].o2i);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a_re, a_im, b_re, b_im, int'(tw_idx), scale));
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the pair.
    task automatic send(input longint ar, ai, br, bi, input int k, input bit s);
        int t;
        a_re = DW'(ar); a_im = DW'(ai); b_re = DW'(br); b_im = DW'(bi);
        tw_idx = 7'(k); scale = s; in_valid = 1'b1;
        t = 0;
        @(negedge clock);
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("send_timeout", longint'(in_ready), 1);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_lit(input string name, input longint e1r, e1i, e2r, e2i);
        int t;
        t = 0;
        @(negedge clock);
        while (!out_valid && t < 20) begin
            @(negedge clock);
            t++;
        end
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_o1r"}, o1r, e1r);
        check({name, "_o1i"}, o1i, e1i);
        check({name, "_o2r"}, o2r, e2r);
        check({name, "_o2i"}, o2i, e2i);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        check("tw_k0_re", tw(0, 1'b0), 1048576);
        check("tw_k0_im", tw(0, 1'b1), 0);
        check("tw_k32_re", tw(32, 1'b0), 741455);
        check("tw_k32_im", tw(32, 1'b1), 741455);
        check("tw_k64_re", tw(64, 1'b0), 0);
        check("tw_k64_im", tw(64, 1'b1), 1048576);
        check("tw_k127_re", tw(127, 1'b0), -1048260);
        check("tw_k127_im", tw(127, 1'b1), 25733);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_o1r", o1r, 0);
        check("rst_o2i", o2i, 0);
        @(posedge clock);
        #1;

        // Exact four-cycle latency on an idle pipeline.
        send(1000, 0, 200, 0, 0, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("lat_early", longint'(out_valid), 0);
        @(negedge clock);
        check("lat_valid", longint'(out_valid), 1);
        check("lat_o1r", o1r, 1200);
        check("lat_o1i", o1i, 0);
        check("lat_o2r", o2r, 800);
        check("lat_o2i", o2i, 0);
        @(posedge clock);
        #1;

        send(3000, 0, 1000, 0, 64, 1'b0);
        in_valid = 1'b0;
        wait_lit("k64", 4000, 0, 0, 2000);
        send(5, 0, 2, 0, 0, 1'b1);
        in_valid = 1'b0;
        wait_lit("scale", 4, 0, 2, 0);
        send(536870911, -536870912, 536870911, -536870912, 0, 1'b0);
        in_valid = 1'b0;
        wait_lit("sat", 536870911, -536870912, 0, 0);
        send(-5, -3, 2, 0, 0, 1'b1);
        in_valid = 1'b0;
        wait_lit("neg_round", -1, -1, -3, -1);
        send(536870911, 0, -536870912, 0, 0, 1'b1);
        in_valid = 1'b0;
        wait_lit("diff_max_half", 0, 0, 536870911, 0);

        // Model-checked vectors across the twiddle range, with bubbles.
        send(123456, -98765, -4321, 55555, 1, 1'b0);
        send(-536870912, 536870911, 536870911, -536870912, 32, 1'b0);
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        send(77777, 11111, -22222, 99999, 100, 1'b1);
        send(-300000, 250000, 150000, -50000, 127, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        send(400000000, -400000000, -400000000, 400000000, 45, 1'b0);
        send(-1, -1, 0, 0, 96, 1'b1);
        in_valid = 1'b0;

        // Six back-to-back pairs with a three-cycle output stall in the middle.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(1000 * i + 7, -300 * i, 250 - 90 * i, 11 * i, 21 * i, i[0]);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    check("stall_in_ready", longint'(in_ready), 0);
                end
                @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join

        t = 0;
        while (exp_q.size() > 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("drain_empty", longint'(exp_q.size()), 0);
        @(posedge clock);
        #1;

        // Reset with three pairs in flight and a pair offered on the reset cycle.
        send(100, 1, 2, 3, 5, 1'b0);
        send(200, 4, 5, 6, 6, 1'b0);
        send(300, 7, 8, 9, 7, 1'b0);
        a_re = 999;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("flush_valid", longint'(out_valid), 0);
        check("flush_o1r", o1r, 0);
        check("flush_o1i", o1i, 0);
        check("flush_o2r", o2r, 0);
        check("flush_o2i", o2i, 0);
        repeat (8) begin
            @(negedge clock);
            check("flush_no_emit", longint'(out_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
